// File: rtl/seq_mult_mac_pkg.sv
// Shared types and elaboration helpers for the iterative multiply / MAC unit.
package seq_mult_mac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  function automatic int calc_iters(input int width, input int step);
    return width / step;
  endfunction

  // One spare bit so the counter can hold N itself without wrapping.
  function automatic int calc_cnt_w(input int width, input int step);
    return $clog2(width / step) + 1;
  endfunction

  function automatic bit step_divides(input int width, input int step);
    return (step > 0) && (step <= width) && ((width % step) == 0);
  endfunction

endpackage

// File: rtl/mult_step_unit.sv
// One shift-add iteration: adds |a| times a STEP-bit slice of |b| at the slice's weight.
module mult_step_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = 6
) (
  input  logic [2*WIDTH-1:0] partial,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [STEP-1:0]    b_slice,
  input  logic [CNT_W-1:0]   count,
  output logic [2*WIDTH-1:0] next_partial
);

  logic [WIDTH+STEP-1:0] prod;
  logic [2*WIDTH-1:0]    term;

  always_comb begin
    prod         = (WIDTH+STEP)'(a_mag) * (WIDTH+STEP)'(b_slice);
    term         = (2*WIDTH)'(prod) << (32'(count) * STEP);
    next_partial = partial + term;
  end

endmodule

// File: rtl/seq_mult_mac.sv
// Iterative signed/unsigned multiplier with optional accumulate, STEP multiplier
// bits retired per cycle, start/busy handshake and a one-cycle done pulse.
module seq_mult_mac
  import seq_mult_mac_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 acc_i,
  input  logic [WIDTH-1:0]     a_bi,
  input  logic [WIDTH-1:0]     b_bi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   y_bo
);

  localparam int N     = calc_iters(WIDTH, STEP);
  localparam int CNT_W = calc_cnt_w(WIDTH, STEP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (!step_divides(WIDTH, STEP)) begin : g_bad_step
      $error("seq_mult_mac: STEP must divide WIDTH");
    end
  endgenerate

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct unsigned magnitude.
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                          input logic neg);
    return neg ? $signed(-mag) : $signed(mag);
  endfunction

  function automatic logic [2*WIDTH-1:0] accumulate(input logic [2*WIDTH-1:0] y_prev,
                                                   input logic signed [2*WIDTH-1:0] prod,
                                                   input logic acc);
    return acc ? (y_prev + $unsigned(prod)) : $unsigned(prod);
  endfunction

  state_t              state_q, state_d;
  logic                load, finish;
  logic [CNT_W-1:0]    count_q;
  logic [WIDTH-1:0]    a_mag_q;
  logic [WIDTH-1:0]    b_rem_q;
  logic                neg_q;
  logic                acc_q;
  logic [2*WIDTH-1:0]  part_q;
  logic [2*WIDTH-1:0]  part_d;
  logic signed [2*WIDTH-1:0] prod_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = WORK;
        end
      end
      WORK: begin
        if (count_q == LAST) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == WORK);

  mult_step_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .CNT_W (CNT_W)
  ) u_step (
    .partial      (part_q),
    .a_mag        (a_mag_q),
    .b_slice      (b_rem_q[STEP-1:0]),
    .count        (count_q),
    .next_partial (part_d)
  );

  assign prod_s = apply_sign(part_d, neg_q);

  // Operand latch at acceptance, shift-add during WORK, result write on the last iteration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_mag_q <= '0;
      b_rem_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= 1'b0;
      part_q  <= '0;
      count_q <= '0;
      y_bo    <= '0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (load) begin
        a_mag_q <= magnitude(a_bi, signed_i);
        b_rem_q <= magnitude(b_bi, signed_i);
        neg_q   <= signed_i & (a_bi[WIDTH-1] ^ b_bi[WIDTH-1]);
        acc_q   <= acc_i;
        part_q  <= '0;
        count_q <= '0;
      end else if (state_q == WORK) begin
        part_q  <= part_d;
        b_rem_q <= b_rem_q >> STEP;
        count_q <= count_q + CNT_W'(1);
        if (finish) begin
          y_bo   <= accumulate(y_bo, prod_s, acc_q);
          done_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_mac.sv
// Bench for seq_mult_mac: directed and random operations on STEP=1 and STEP=4 instances.
module tb_seq_mult_mac;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start1, sgn1, acc1, busy1, done1;
  logic [W-1:0] a1, b1;
  logic [2*W-1:0] y1;
  logic start4, sgn4, acc4, busy4, done4;
  logic [W-1:0] a4, b4;
  logic [2*W-1:0] y4;

  seq_mult_mac #(.WIDTH(W), .STEP(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .signed_i(sgn1), .acc_i(acc1),
    .a_bi(a1), .b_bi(b1), .busy_o(busy1), .done_o(done1), .y_bo(y1));

  seq_mult_mac #(.WIDTH(W), .STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .signed_i(sgn4), .acc_i(acc4),
    .a_bi(a4), .b_bi(b4), .busy_o(busy4), .done_o(done4), .y_bo(y4));

  int tests = 0;
  int fails = 0;
  int done_seen1 = 0;
  logic [63:0] ym1, ym4;

  always @(negedge clk) if (done1) done_seen1++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer multiply of the operands as interpreted by the mode.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    return 64'(sa * sb);
  endfunction

  task automatic drive(input bit use4, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic sg, input logic ac);
    if (use4) begin
      start4 = st; a4 = a; b4 = b; sgn4 = sg; acc4 = ac;
    end else begin
      start1 = st; a1 = a; b1 = b; sgn1 = sg; acc1 = ac;
    end
  endtask

  task automatic do_op(input bit use4, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic acc, input string tag);
    int n;
    int cycles;
    logic [63:0] exp;
    n = use4 ? 8 : 32;
    exp = ref_mul(a, b, sgn);
    if (use4) begin
      if (acc) exp = exp + ym4;
      ym4 = exp;
    end else begin
      if (acc) exp = exp + ym1;
      ym1 = exp;
    end
    @(negedge clk);
    drive(use4, 1'b1, a, b, sgn, acc);
    @(negedge clk);
    check({tag, "_busy_rise"}, 64'(use4 ? busy4 : busy1), 64'(1));
    cycles = 0;
    while ((use4 ? busy4 : busy1) && cycles < n + 5) begin
      cycles++;
      drive(use4, (cycles < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cycles), 64'(n));
    check({tag, "_done"}, 64'(use4 ? done4 : done1), 64'(1));
    check({tag, "_y"}, use4 ? y4 : y1, exp);
    @(negedge clk);
    check({tag, "_done_low"}, 64'(use4 ? done4 : done1), 64'(0));
    check({tag, "_y_hold"}, use4 ? y4 : y1, exp);
  endtask

  initial begin
    logic [63:0] expq[$];
    logic [63:0] e;
    int cyc, last_acc, done_n, base;
    logic prev_busy;

    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    ym1 = '0;
    ym4 = '0;
    #3;
    check("rst_busy1", 64'(busy1), 64'(0));
    check("rst_done1", 64'(done1), 64'(0));
    check("rst_y1", y1, 64'(0));
    check("rst_busy4", 64'(busy4), 64'(0));
    check("rst_y4", y4, 64'(0));
    @(negedge clk);
    rst = 1'b0;

    do_op(1'b0, 32'd3, 32'd5, 1'b0, 1'b0, "t1");
    check("t1_const", y1, 64'h000000000000000F);
    do_op(1'b0, 32'd2, 32'd3, 1'b0, 1'b1, "t4a");
    check("t4a_const", y1, 64'd21);
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "t2");
    check("t2_const", y1, 64'hFFFFFFFE00000001);
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, "t4b");
    check("t4b_const", y1, 64'hFFFFFFFC00000002);
    do_op(1'b0, 32'hFFFFFFFF, 32'd7, 1'b1, 1'b0, "t3a");
    check("t3a_const", y1, 64'hFFFFFFFFFFFFFFF9);
    do_op(1'b0, 32'h80000000, 32'h80000000, 1'b1, 1'b0, "t3b");
    check("t3b_const", y1, 64'h4000000000000000);
    do_op(1'b0, 32'h80000000, 32'd1, 1'b1, 1'b0, "t3c");
    check("t3c_const", y1, 64'hFFFFFFFF80000000);

    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd1");
      do_op(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd4");
    end
    do_op(1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b0, "s4_minneg");

    // Back-to-back stream with start held high and operands changing every cycle.
    @(negedge clk);
    prev_busy = busy1;
    drive(1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    cyc = 0;
    last_acc = -1;
    done_n = 0;
    while (done_n < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!prev_busy && busy1) begin
        expq.push_back(ref_mul(a1, b1, sgn1));
        if (last_acc >= 0) check("stream_interval", 64'(cyc - last_acc), 64'(33));
        last_acc = cyc;
      end
      if (done1) begin
        e = (expq.size() > 0) ? expq.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        check("stream_y", y1, e);
        ym1 = e;
        done_n++;
      end
      prev_busy = busy1;
      if (done_n == 5) start1 = 1'b0;
      else drive(1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    check("stream_ops", 64'(done_n), 64'(5));

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'd9, 32'd11, 1'b0, 1'b0);
    @(negedge clk);
    start1 = 1'b0;
    repeat (9) begin
      @(negedge clk);
      a1 = $urandom;
      b1 = $urandom;
    end
    #2;
    base = done_seen1;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy1), 64'(0));
    check("arst_y", y1, 64'(0));
    check("arst_done", 64'(done1), 64'(0));
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_no_done", 64'(done_seen1), 64'(base));
    ym1 = '0;
    ym4 = '0;
    do_op(1'b0, 32'd6, 32'd7, 1'b0, 1'b0, "post_rst");
    check("post_rst_42", y1, 64'd42);
    do_op(1'b1, 32'd6, 32'd7, 1'b0, 1'b0, "step4");
    check("step4_42", y4, 64'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
